// File: rtl/writeback_buffer_pkg.sv
// -----------------------------------------------------------------------------
// writeback_buffer_pkg
//   Shared widths and types for the write-back buffer and the 4x16 register
//   file it feeds. The register file uses the same ADDR_W / DATA_W.
//
//   ADDR_W        register index width
//   DATA_W        register data width
//   DEPTH_DEFAULT default number of buffer entries (power of two, >= 2)
//   wb_entry_t    one pending register write {idx, data}
// -----------------------------------------------------------------------------
package writeback_buffer_pkg;

  localparam int ADDR_W        = 2;
  localparam int DATA_W        = 16;
  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_buffer_fwd_lookup.sv
// -----------------------------------------------------------------------------
// writeback_buffer_fwd_lookup
//   Combinational forwarding scan for one read port. Walks the pending entries
//   from oldest (head) to youngest so the last match seen is the youngest one.
//
//   entries  entry storage array
//   valid    per-slot valid bits
//   head     index of the oldest pending entry
//   count    number of pending entries
//   index    register index being looked up
//   hit      some pending entry targets index
//   data     youngest matching entry's data, 0 when no hit
// -----------------------------------------------------------------------------
module writeback_buffer_fwd_lookup
  import writeback_buffer_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      head,
  input  logic [CNT_W-1:0]      count,
  input  logic [ADDR_W-1:0]     index,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  logic [PTR_W-1:0] pos;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    pos  = head;
    for (int k = 0; k < DEPTH; k++) begin
      // Offset from head wraps naturally in PTR_W bits (DEPTH is a power of two).
      pos = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && valid[pos] && (entries[pos].idx == index)) begin
        hit  = 1'b1;
        data = entries[pos].data;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// -----------------------------------------------------------------------------
// writeback_buffer
//   In-order FIFO of pending register writes; sole driver of the register
//   file write port. Retires at most one entry per cycle when drain_en is set
//   and offers two forwarding lookups mirroring the file's read ports.
//
//   clk, reset_n          clock, async active-low reset
//   in_valid/in_ready     request handshake; in_ready = not full
//   in_reg, in_data       destination index and value of the request
//   drain_en              permit retirement this cycle
//   write_reg/write_data  head entry (0 when empty) to the register file
//   reg_write             register file write enable
//   read1/read2           lookup indices
//   fwd_hit1/2,fwd_data1/2 forwarding results (youngest pending value)
//   empty, count          occupancy
// -----------------------------------------------------------------------------
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              drain_en,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  input  logic [ADDR_W-1:0] read1,
  input  logic [ADDR_W-1:0] read2,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  push;
  logic                  retire;

  // in_ready depends only on registered count, never on in_valid/drain_en.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign push      = in_valid && in_ready;
  assign retire    = drain_en && !empty;
  assign reg_write = retire;

  always_comb begin
    write_reg  = '0;
    write_data = '0;
    if (!empty) begin
      write_reg  = entries[head].idx;
      write_data = entries[head].data;
    end
  end

  // head == tail only when empty or full, and then only one of push/retire can
  // fire, so the two valid-bit updates never target the same slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entries <= '0;
      valid   <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        entries[tail] <= '{idx: in_reg, data: in_data};
        valid[tail]   <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (retire) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({push, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  writeback_buffer_fwd_lookup #(.DEPTH(DEPTH)) u_fwd1 (
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .count   (count),
    .index   (read1),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  writeback_buffer_fwd_lookup #(.DEPTH(DEPTH)) u_fwd2 (
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .count   (count),
    .index   (read2),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );

endmodule

// File: tb/tb_writeback_buffer.sv
module tb_writeback_buffer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_reg;
  logic [15:0] in_data;
  logic        drain_en;
  logic [1:0]  write_reg;
  logic [15:0] write_data;
  logic        reg_write;
  logic [1:0]  read1;
  logic [1:0]  read2;
  logic        fwd_hit1;
  logic [15:0] fwd_data1;
  logic        fwd_hit2;
  logic [15:0] fwd_data2;
  logic        empty;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  writeback_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .drain_en(drain_en),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read1(read1), .read2(read2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file-side log of every write that actually lands.
  logic [17:0] wlog[$];
  always @(posedge clk) begin
    if (reset_n && reg_write) wlog.push_back({write_reg, write_data});
  end

  typedef struct {
    logic        iv;
    logic [1:0]  ir;
    logic [15:0] id;
    logic        de;
    logic [1:0]  r1;
    logic [1:0]  r2;
    logic        rdy;
    logic        emp;
    logic [2:0]  cnt;
    logic        rw;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic        h1;
    logic [15:0] d1;
    logic        h2;
    logic [15:0] d2;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk(logic iv, logic [1:0] ir, logic [15:0] id, logic de,
                              logic [1:0] r1, logic [1:0] r2,
                              logic rdy, logic emp, logic [2:0] cnt, logic rw,
                              logic [1:0] wr, logic [15:0] wd,
                              logic h1, logic [15:0] d1, logic h2, logic [15:0] d2);
    vec_t v;
    v.iv = iv; v.ir = ir; v.id = id; v.de = de; v.r1 = r1; v.r2 = r2;
    v.rdy = rdy; v.emp = emp; v.cnt = cnt; v.rw = rw; v.wr = wr; v.wd = wd;
    v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".in_ready"},   32'(in_ready),   32'd1);
    chk({tag, ".empty"},      32'(empty),      32'd1);
    chk({tag, ".count"},      32'(count),      32'd0);
    chk({tag, ".reg_write"},  32'(reg_write),  32'd0);
    chk({tag, ".write_reg"},  32'(write_reg),  32'd0);
    chk({tag, ".write_data"}, 32'(write_data), 32'd0);
    chk({tag, ".fwd_hit1"},   32'(fwd_hit1),   32'd0);
    chk({tag, ".fwd_data1"},  32'(fwd_data1),  32'd0);
    chk({tag, ".fwd_hit2"},   32'(fwd_hit2),   32'd0);
    chk({tag, ".fwd_data2"},  32'(fwd_data2),  32'd0);
  endtask

  logic [17:0] exp_log[8];

  initial begin
    //               iv ir  id       de r1 r2   rdy emp cnt rw wr wd       h1 d1       h2 d2
    // single write, drain on
    vecs[0]  = mk(1, 2, 16'h1234, 1, 2, 0,   1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 2, 0,   1, 0, 1, 1, 2, 16'h1234, 1, 16'h1234, 0, 16'h0000);
    vecs[2]  = mk(0, 0, 16'h0000, 0, 2, 0,   1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    // fill under stall
    vecs[3]  = mk(1, 0, 16'h0001, 0, 0, 2,   1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    vecs[4]  = mk(1, 1, 16'h0002, 0, 0, 2,   1, 0, 1, 0, 0, 16'h0001, 1, 16'h0001, 0, 16'h0000);
    vecs[5]  = mk(1, 0, 16'h0003, 0, 0, 2,   1, 0, 2, 0, 0, 16'h0001, 1, 16'h0001, 0, 16'h0000);
    vecs[6]  = mk(1, 3, 16'h0004, 0, 0, 2,   1, 0, 3, 0, 0, 16'h0001, 1, 16'h0003, 0, 16'h0000);
    vecs[7]  = mk(1, 2, 16'h0005, 0, 0, 2,   0, 0, 4, 0, 0, 16'h0001, 1, 16'h0003, 0, 16'h0000);
    // full with simultaneous drain; fifth push held then accepted (tail wraps)
    vecs[8]  = mk(1, 2, 16'h0005, 1, 0, 3,   0, 0, 4, 1, 0, 16'h0001, 1, 16'h0003, 1, 16'h0004);
    vecs[9]  = mk(1, 2, 16'h0005, 0, 0, 2,   1, 0, 3, 0, 1, 16'h0002, 1, 16'h0003, 0, 16'h0000);
    vecs[10] = mk(0, 0, 16'h0000, 1, 2, 1,   0, 0, 4, 1, 1, 16'h0002, 1, 16'h0005, 1, 16'h0002);
    vecs[11] = mk(0, 0, 16'h0000, 1, 0, 3,   1, 0, 3, 1, 0, 16'h0003, 1, 16'h0003, 1, 16'h0004);
    // push and retire together at count=2
    vecs[12] = mk(1, 1, 16'h00AA, 1, 1, 2,   1, 0, 2, 1, 3, 16'h0004, 0, 16'h0000, 1, 16'h0005);
    vecs[13] = mk(1, 2, 16'h00BB, 1, 1, 2,   1, 0, 2, 1, 2, 16'h0005, 1, 16'h00AA, 1, 16'h0005);
    vecs[14] = mk(0, 0, 16'h0000, 1, 2, 1,   1, 0, 2, 1, 1, 16'h00AA, 1, 16'h00BB, 1, 16'h00AA);
    vecs[15] = mk(0, 0, 16'h0000, 1, 2, 0,   1, 0, 1, 1, 2, 16'h00BB, 1, 16'h00BB, 0, 16'h0000);
    vecs[16] = mk(0, 0, 16'h0000, 1, 2, 0,   1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);

    exp_log[0] = {2'd2, 16'h1234};
    exp_log[1] = {2'd0, 16'h0001};
    exp_log[2] = {2'd1, 16'h0002};
    exp_log[3] = {2'd0, 16'h0003};
    exp_log[4] = {2'd3, 16'h0004};
    exp_log[5] = {2'd2, 16'h0005};
    exp_log[6] = {2'd1, 16'h00AA};
    exp_log[7] = {2'd2, 16'h00BB};

    reset_n = 1'b1; in_valid = 0; in_reg = 0; in_data = 0; drain_en = 0; read1 = 0; read2 = 0;

    // Reset asserted mid-cycle, before any clock edge: outputs must follow at once.
    #1 reset_n = 1'b0;
    #1 chk_idle_reset("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk_idle_reset("post_reset");

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = vecs[i].iv; in_reg = vecs[i].ir; in_data = vecs[i].id;
      drain_en = vecs[i].de; read1 = vecs[i].r1; read2 = vecs[i].r2;
      #1;
      chk($sformatf("v%0d.in_ready", i),   32'(in_ready),   32'(vecs[i].rdy));
      chk($sformatf("v%0d.empty", i),      32'(empty),      32'(vecs[i].emp));
      chk($sformatf("v%0d.count", i),      32'(count),      32'(vecs[i].cnt));
      chk($sformatf("v%0d.reg_write", i),  32'(reg_write),  32'(vecs[i].rw));
      chk($sformatf("v%0d.write_reg", i),  32'(write_reg),  32'(vecs[i].wr));
      chk($sformatf("v%0d.write_data", i), 32'(write_data), 32'(vecs[i].wd));
      chk($sformatf("v%0d.fwd_hit1", i),   32'(fwd_hit1),   32'(vecs[i].h1));
      chk($sformatf("v%0d.fwd_data1", i),  32'(fwd_data1),  32'(vecs[i].d1));
      chk($sformatf("v%0d.fwd_hit2", i),   32'(fwd_hit2),   32'(vecs[i].h2));
      chk($sformatf("v%0d.fwd_data2", i),  32'(fwd_data2),  32'(vecs[i].d2));
    end

    // Reset in the middle of a drain: three entries pending, nothing may land.
    @(negedge clk);
    drain_en = 0; in_valid = 1; in_reg = 3; in_data = 16'h0111; read1 = 3; read2 = 1;
    @(negedge clk);
    in_reg = 1; in_data = 16'h0222;
    @(negedge clk);
    in_reg = 2; in_data = 16'h0333;
    @(negedge clk);
    in_valid = 0;
    #1;
    chk("rst6.count_before", 32'(count), 32'd3);
    chk("rst6.fwd_data1_before", 32'(fwd_data1), 32'h0111);
    chk("rst6.reg_write_stalled", 32'(reg_write), 32'd0);
    #1 drain_en = 1;
    #1 chk("rst6.reg_write_armed", 32'(reg_write), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk_idle_reset("rst6");
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rst6.after%0d.empty", c), 32'(empty), 32'd1);
      chk($sformatf("rst6.after%0d.reg_write", c), 32'(reg_write), 32'd0);
      @(negedge clk);
    end
    drain_en = 0;

    chk("log.size", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wlog.size())
        chk($sformatf("log[%0d]", i), 32'(wlog[i]), 32'(exp_log[i]));
      else
        chk($sformatf("log[%0d].missing", i), 32'hDEAD, 32'(exp_log[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_buffer.md
Name: writeback_buffer

Overview:
- Write-side companion to the 4x16 register file; the sole driver of its write port (write_reg, write_data, reg_write).
- Accepts register-write requests from the datapath with a valid/ready handshake.
- Queues them in order in a small FIFO and retires one per cycle into the register file.
- Offers two forwarding lookups that mirror the file's two read ports, so readers see pending (not yet retired) values.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2
- DATA_W, 16, register data width
- ADDR_W, 2, register index width

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  write request present
- in_ready  output  1  buffer can accept a request; equals not full
- in_reg  input  ADDR_W  destination register index
- in_data  input  DATA_W  value to write
- drain_en  input  1  allow retirement this cycle (0 = stall the drain)
- write_reg  output  ADDR_W  register file write index (head entry)
- write_data  output  DATA_W  register file write data (head entry)
- reg_write  output  1  register file write enable
- read1  input  ADDR_W  lookup index, port 1
- read2  input  ADDR_W  lookup index, port 2
- fwd_hit1  output  1  a pending entry targets read1
- fwd_data1  output  DATA_W  youngest pending value for read1
- fwd_hit2  output  1  a pending entry targets read2
- fwd_data2  output  DATA_W  youngest pending value for read2
- empty  output  1  no pending entries
- count  output  clog2(DEPTH)+1  number of pending entries

Behaviour:
- Reset (reset_n low, asynchronous): head pointer, tail pointer and count = 0; all entry valid bits = 0. Outputs: in_ready=1, empty=1, reg_write=0, fwd_hit1/2=0, fwd_data1/2=0, write_reg=0, write_data=0. Reset asserted mid-operation discards all pending writes; none reach the register file.
- Push: in_valid && in_ready at posedge writes {in_reg, in_data} at the tail; tail advances modulo DEPTH; count+1.
- in_ready = (count != DEPTH). It must not depend combinationally on drain_en or in_valid.
- Retire: reg_write = drain_en && !empty (combinational). write_reg/write_data = head entry, or 0 when empty. On a posedge with reg_write=1: the register file captures the entry; head advances modulo DEPTH; count-1.
- Simultaneous push and retire (not full): both occur; count unchanged.
- Full: the request is held off; the same-cycle retire still happens, so in_ready rises the next cycle.
- Empty with a push: the entry becomes visible next cycle. There is no same-cycle pass-through; minimum latency from accepted push to reg_write is 1 cycle.
- Forwarding (combinational):
  - Scan all valid entries. fwd_hitN=1 if any entry's reg == readN.
  - fwd_dataN = data of the youngest matching entry (closest to the tail), else 0.
  - The head entry being retired this cycle still counts as pending; the register file holds the old value until the edge.
  - An entry pushed this cycle is not visible until the next cycle.
- Ordering: writes retire strictly in acceptance order. Repeated writes to one register all retire; the last one wins in the file.
- Pointers wrap modulo DEPTH; count distinguishes full from empty. Overflow and underflow are impossible by construction.

Decomposition:
- Shared package: ADDR_W, DATA_W, default DEPTH, and the entry struct/typedef {reg index, data}. The register file uses the same widths.
- One natural sub-module: fwd_lookup. It scans the entry array given head and count and returns {hit, data} for one index; instantiate it twice.

Test Plan:
1. Reset then idle:
   - reset_n low mid-cycle -> all outputs at reset values immediately; in_ready=1, empty=1, reg_write=0.
2. Single write with drain_en=1:
   - Push {R2, 0x1234} -> next cycle reg_write=1, write_reg=2, write_data=0x1234, fwd_hit(read=2)=1, fwd_data=0x1234.
   - Following cycle: empty=1, fwd_hit=0.
3. Fill under stall:
   - drain_en=0; push R0=0x0001, R1=0x0002, R0=0x0003, R3=0x0004 -> count=4, in_ready=0.
   - read1=0 -> fwd_data1=0x0003 (youngest). read2=2 -> fwd_hit2=0.
   - A fifth push is held off.
4. Full with simultaneous drain:
   - From state 3, drain_en=1 with in_valid held -> retire R0=0x0001; next cycle in_ready=1.
   - Push accepted; retire order is 0x0001, 0x0002, 0x0003, 0x0004, then the new entry. Pointers wrap cleanly.
5. Push and retire in the same cycle:
   - count=2 with a push and drain -> count stays 2; order is preserved.
6. Reset mid-drain:
   - 3 entries pending; assert reset_n low -> reg_write=0 immediately.
   - After release: empty=1, and no pending data is ever written.
